cpu_data_arbiter: RTL
=====================

// Module: cpu_data_arbiter
//
// PURPOSE
//   Registered, parametrised successor to the combinational CPU data mux. Selects one of COUNT
//   sources onto the CPU read-data bus, registering data_o/oe_o, resolving multiple-OE contention
//   by fixed priority instead of halting, and emulating PET open-bus hold (last driven value lingers).
//   Sits between address-decoded peripherals (RAM, VIA/PIA, CRTC, SPI bridge) and the CPU data pins.
//
// PARAMETERS
//   COUNT        3            number of data sources (>=1); index 0 = highest priority
//   WIDTH        DATA_WIDTH   data bus width in bits (common_pkg, 8)
//   HOLD_CYCLES  4            cycles data_o keeps last driven value after OE drops (0 = no hold)
//   IDLE_VALUE   'hFF         data_o value when idle and hold expired
//   CNT_WIDTH    8            width of saturating contention counter
//
// PORTS
//   clock_i             in   1               system clock
//   reset_i             in   1               synchronous, active-high reset
//   data_i              in   COUNT x WIDTH   per-source data
//   oe_i                in   COUNT           per-source output enable
//   clear_i             in   1               clears sticky flag, mask and counter
//   data_o              out  WIDTH           registered selected data
//   oe_o                out  1               registered: a source is driving
//   sel_o               out  $clog2(COUNT)   registered index of winning source (0 when none)
//   contention_o        out  1               1-cycle pulse: >1 oe_i bit set in previous cycle
//   contention_sticky_o out  1               set on contention until clear_i/reset
//   contention_mask_o   out  COUNT           oe_i captured at first contention since clear (LOG only)
//   contention_count_o  out  CNT_WIDTH       saturating count of contended cycles (LOG only)
//
// BEHAVIOUR
//   - Reset (sync, any state, mid-hold included): state=IDLE, data_o=IDLE_VALUE, oe_o=0, sel_o=0,
//     contention_o=0, sticky=0, mask=0, count=0; hold counter=0. Effective on next clock edge.
//   - Latency: exactly 1 clock from oe_i/data_i to data_o/oe_o/sel_o/contention_o.
//   - Selection: winner = lowest set index of oe_i. Data of the winner registered every cycle it is
//     enabled (data change while enabled propagates after 1 cycle).
//   - Contention: popcount(oe_i)>1 -> winner still driven, contention_o=1 next cycle, sticky set.
//   - FSM (registered state):
//       IDLE  : oe_o=0, data_o=IDLE_VALUE. any oe_i -> DRIVE.
//       DRIVE : oe_o=1, data_o=winner data. oe_i==0 -> HOLD (HOLD_CYCLES>0) else IDLE.
//       HOLD  : oe_o=0, data_o=last driven value; hold counter loads HOLD_CYCLES-1 on entry,
//               decrements; any oe_i -> DRIVE (preempts hold); counter==0 && oe_i==0 -> IDLE.
//   - HOLD lasts exactly HOLD_CYCLES cycles of oe_o=0 with held data before IDLE_VALUE appears.
//   - Simultaneous clear_i and contention: clear applied first, then event logged
//     (sticky=1, count=1, mask=current oe_i).
//   - COUNT==1: sel_o is 1 bit tied 0; contention never asserts.
//   - Counter saturates at all-ones; no wrap.
//
// CONFIGURATION
//   Macro CPU_DATA_ARBITER_CONTENTION_LOG_EN:
//     defined   : contention_mask_o and contention_count_o implemented as above.
//     undefined : both outputs tied to 0; no mask/counter flops; contention_o and
//                 contention_sticky_o unchanged. Port list identical either way.
//
// STRUCTURE
//   - common_pkg: DATA_WIDTH (existing); add typedef enum logic [1:0] {ARB_IDLE, ARB_DRIVE,
//     ARB_HOLD} arb_state_t and localparam ARB_IDLE_VALUE = 8'hFF.
//   - Sub-module onehot_priority_enc #(COUNT): combinational, oe -> {valid, index, multi}.
//   - Simulation-only: assert sel_o < COUNT; assert oe_o implies state==ARB_DRIVE.
//
// TESTING  (COUNT=3, HOLD_CYCLES=4, IDLE_VALUE=FF; data_i = AA/BB/CC)
//   1 Reset: assert reset_i 2 cycles -> data_o=FF, oe_o=0, sel_o=0, sticky=0, count=0.
//   2 Single drivers: oe_i=001/010/100 -> one cycle later data_o=AA/BB/CC, sel_o=0/1/2, oe_o=1;
//     data_i[2]<=DD while enabled -> data_o=DD next cycle.
//   3 Hold: drive 010 then oe_i=000 -> oe_o=0, data_o=BB for 4 cycles, then FF; repeat with
//     oe_i=100 asserted on 2nd hold cycle -> DRIVE, data_o=CC, no FF seen.
//   4 Contention: oe_i=110 1 cycle -> data_o=BB, sel_o=1, contention_o pulse 1 cycle,
//     sticky=1, mask=110, count=1; then oe_i=111 -> mask stays 110, count=2.
//   5 Clear/saturation: clear_i with oe_i=011 same cycle -> sticky=1, count=1, mask=011;
//     CNT_WIDTH=2 build, 5 contended cycles -> count=3.
//   6 Reset mid-hold (cycle 2 of HOLD) -> next cycle IDLE, data_o=FF; macro-off build: mask/count=0.

Source files
------------

// File: rtl/common_pkg.sv
// Shared CPU data-bus definitions: bus width, arbiter state encoding and idle bus value.
package common_pkg;

  localparam int DATA_WIDTH = 8;
  localparam logic [7:0] ARB_IDLE_VALUE = 8'hFF;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DRIVE,
    ARB_HOLD
  } arb_state_t;

endpackage

// File: rtl/onehot_priority_enc.sv
// Combinational priority encoder: the lowest set bit of i_oe wins; o_multi flags more than one set bit.
module onehot_priority_enc #(
  parameter int COUNT = 3,
  parameter int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic [COUNT-1:0] i_oe,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_index,
  output logic             o_multi
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    o_index = '0;
    for (int i = COUNT - 1; i >= 0; i--) begin
      if (i_oe[i]) o_index = IDX_W'(i);
    end
  end

  assign o_valid = |i_oe;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign o_multi = |(i_oe & (i_oe - COUNT'(1)));

endmodule

// File: rtl/cpu_data_arbiter.sv
// Registered CPU read-data arbiter with fixed-priority contention handling and open-bus hold.
// Optional contention logging (mask and saturating counter) is built when CPU_DATA_ARBITER_CONTENTION_LOG_EN is defined.
module cpu_data_arbiter
  import common_pkg::*;
#(
  parameter int                COUNT       = 3,
  parameter int                WIDTH       = DATA_WIDTH,
  parameter int                HOLD_CYCLES = 4,
  parameter logic [WIDTH-1:0]  IDLE_VALUE  = WIDTH'(ARB_IDLE_VALUE),
  parameter int                CNT_WIDTH   = 8
) (
  input  logic                                      clock_i,
  input  logic                                      reset_i,
  input  logic [COUNT*WIDTH-1:0]                    data_i,
  input  logic [COUNT-1:0]                          oe_i,
  input  logic                                      clear_i,
  output logic [WIDTH-1:0]                          data_o,
  output logic                                      oe_o,
  output logic [((COUNT > 1) ? $clog2(COUNT) : 1)-1:0] sel_o,
  output logic                                      contention_o,
  output logic                                      contention_sticky_o,
  output logic [COUNT-1:0]                          contention_mask_o,
  output logic [CNT_WIDTH-1:0]                      contention_count_o
);

  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HC_W'(HOLD_CYCLES - 1) : '0;

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [HC_W-1:0]  r_hold_cnt;
  logic [HC_W-1:0]  w_hold_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic [IDX_W-1:0] r_sel;
  logic             r_contention;
  logic             r_sticky;

  logic             w_valid;
  logic             w_multi;
  logic [IDX_W-1:0] w_index;
  logic [WIDTH-1:0] w_src [COUNT];
  logic [WIDTH-1:0] w_win_data;

  onehot_priority_enc #(
    .COUNT (COUNT),
    .IDX_W (IDX_W)
  ) u_enc (
    .i_oe    (oe_i),
    .o_valid (w_valid),
    .o_index (w_index),
    .o_multi (w_multi)
  );

  for (genvar g = 0; g < COUNT; g++) begin : g_src
    assign w_src[g] = data_i[g*WIDTH +: WIDTH];
  end

  assign w_win_data = w_src[w_index];

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_data_nxt  = r_data;
    case (r_state)
      ARB_IDLE: begin
        if (w_valid) w_state_nxt = ARB_DRIVE;
      end
      ARB_DRIVE: begin
        if (!w_valid) begin
          if (HOLD_CYCLES > 0) begin
            w_state_nxt = ARB_HOLD;
            w_hold_nxt  = HOLD_LOAD;
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end
      end
      ARB_HOLD: begin
        if (w_valid) begin
          w_state_nxt = ARB_DRIVE;
        end else if (r_hold_cnt == '0) begin
          w_state_nxt = ARB_IDLE;
        end else begin
          w_hold_nxt = r_hold_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase

    // HOLD keeps whatever was last driven, which is the open-bus behaviour.
    case (w_state_nxt)
      ARB_DRIVE: w_data_nxt = w_win_data;
      ARB_IDLE:  w_data_nxt = IDLE_VALUE;
      default:   w_data_nxt = r_data;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state      <= ARB_IDLE;
      r_hold_cnt   <= '0;
      r_data       <= IDLE_VALUE;
      r_sel        <= '0;
      r_contention <= 1'b0;
      r_sticky     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_data       <= w_data_nxt;
      r_sel        <= w_valid ? w_index : '0;
      r_contention <= w_multi;
      r_sticky     <= (r_sticky & ~clear_i) | w_multi;
    end
  end

  assign data_o              = r_data;
  assign oe_o                = (r_state == ARB_DRIVE);
  assign sel_o               = r_sel;
  assign contention_o        = r_contention;
  assign contention_sticky_o = r_sticky;

`ifdef CPU_DATA_ARBITER_CONTENTION_LOG_EN
  logic [COUNT-1:0]     r_mask;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_cnt_base;

  // A same-cycle clear wipes the log first, so a contention then becomes the new first event.
  assign w_cnt_base = clear_i ? '0 : r_count;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_mask  <= '0;
      r_count <= '0;
    end else begin
      if (w_multi && !(r_sticky && !clear_i)) begin
        r_mask <= oe_i;
      end else if (clear_i) begin
        r_mask <= '0;
      end
      if (w_multi && (w_cnt_base != '1)) begin
        r_count <= w_cnt_base + 1'b1;
      end else begin
        r_count <= w_cnt_base;
      end
    end
  end

  assign contention_mask_o  = r_mask;
  assign contention_count_o = r_count;
`else
  assign contention_mask_o  = '0;
  assign contention_count_o = '0;
`endif

`ifndef SYNTHESIS
  a_sel_range: assert property (@(posedge clock_i) 32'(sel_o) < COUNT);
  a_oe_drive:  assert property (@(posedge clock_i) oe_o |-> (r_state == ARB_DRIVE));
`endif

endmodule
